dmem_access_ctrl: RTL

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_if.sv | 41 ++++
 rtl/dmem_access_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_access_if.sv
// Bus bundle between the MEM stage, the data-memory access controller and data memory.
// Handshake: dm_req rises with dm_addr/dm_we/dm_be/dm_wdata stable and holds them until a cycle with dm_ack=1, in which dm_rdata is valid.
interface dmem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  store_be;
    logic [1:0]  load_type;
    logic        flush;

    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  ld_type;
    logic [1:0]  ld_byte;
    logic        err;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    // master: pipeline plus memory, which surround the controller
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, store_be, load_type, flush,
        output dm_ack, dm_rdata,
        input  stall, rd_valid, rd_data, ld_type, ld_byte, err,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, store_be, load_type, flush,
        input  dm_ack, dm_rdata,
        output stall, rd_valid, rd_data, ld_type, ld_byte, err,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns one MEM-stage load/store into a held memory request,
// stalls the pipeline until ack or timeout, and hands load data to the load formatter.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    dmem_access_if.slave       io_bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_stall;
    logic        w_dm_req;
    logic        w_null;
    logic        w_accept;
    logic        w_timeout;
    logic        w_squash_now;

    logic [7:0]  r_cnt;
    logic        r_squash;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [3:0]  r_dm_be;
    logic [1:0]  r_pend_type;
    logic [1:0]  r_pend_byte;
    logic        r_rd_valid;
    logic        r_err;
    logic [31:0] r_rd_data;
    logic [1:0]  r_ld_type;
    logic [1:0]  r_ld_byte;

    // A store with no byte lanes or a load of type "none" never touches memory.
    assign w_null       = io_bus.mem_we ? (io_bus.store_be == 4'b0000)
                                        : (io_bus.load_type == 2'b00);
    assign w_accept     = io_bus.mem_req & ~io_bus.flush & ~w_null;
    assign w_timeout    = (r_cnt == TO_LAST);
    assign w_squash_now = r_squash | io_bus.flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_dm_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next  = ST_BUSY;
                    w_stall = 1'b1;
                end
            end
            ST_BUSY: begin
                w_stall  = 1'b1;
                w_dm_req = 1'b1;
                if (io_bus.dm_ack || w_timeout) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= 8'd0;
            r_squash    <= 1'b0;
            r_dm_we     <= 1'b0;
            r_dm_addr   <= 32'd0;
            r_dm_wdata  <= 32'd0;
            r_dm_be     <= 4'd0;
            r_pend_type <= 2'd0;
            r_pend_byte <= 2'd0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_rd_data   <= 32'd0;
            r_ld_type   <= 2'd0;
            r_ld_byte   <= 2'd0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dm_addr   <= {io_bus.mem_addr[31:2], 2'b00};
                        r_dm_wdata  <= io_bus.mem_wdata;
                        r_dm_be     <= io_bus.mem_we ? io_bus.store_be : 4'b1111;
                        r_dm_we     <= io_bus.mem_we;
                        r_pend_type <= io_bus.load_type;
                        r_pend_byte <= io_bus.mem_addr[1:0];
                        r_cnt       <= 8'd0;
                        r_squash    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (io_bus.flush) r_squash <= 1'b1;
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (io_bus.dm_ack) begin
                        r_cnt <= 8'd0;
                        if (!r_dm_we && !w_squash_now) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= io_bus.dm_rdata;
                            r_ld_type  <= r_pend_type;
                            r_ld_byte  <= r_pend_byte;
                        end
                    end else if (w_timeout) begin
                        r_cnt <= 8'd0;
                        if (!w_squash_now) begin
                            r_err <= 1'b1;
                            if (!r_dm_we) begin
                                r_rd_valid <= 1'b1;
                                r_rd_data  <= 32'd0;
                                r_ld_type  <= r_pend_type;
                                r_ld_byte  <= r_pend_byte;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: r_squash <= 1'b0;
                default: r_squash <= 1'b0;
            endcase
        end
    end

    assign io_bus.stall    = w_stall & ~i_rst;
    assign io_bus.dm_req   = w_dm_req;
    assign io_bus.dm_we    = r_dm_we;
    assign io_bus.dm_addr  = r_dm_addr;
    assign io_bus.dm_wdata = r_dm_wdata;
    assign io_bus.dm_be    = r_dm_be;
    assign io_bus.rd_valid = r_rd_valid;
    assign io_bus.err      = r_err;
    assign io_bus.rd_data  = r_rd_data;
    assign io_bus.ld_type  = r_ld_type;
    assign io_bus.ld_byte  = r_ld_byte;
    assign o_dbg_state     = r_state;

endmodule
